// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//
// Loads a CFG_WIDTH-bit configuration word from a byte stream. A frame is a
// SYNC_BYTE header, CFG_WIDTH/8 data bytes (first byte lands in the MSB) and a
// one-byte XOR checksum of the data bytes. The active configuration (cfg_out)
// only updates when a complete frame passes its checksum, so downstream
// selects never see partially loaded bits.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request to load a frame (honoured in IDLE/DONE/ERR)
//   in_valid   in   in_data is offered
//   in_data    in   [7:0] serial configuration byte
//   in_ready   out  block accepts in_data this cycle (decoded from state only)
//   cfg_out    out  [CFG_WIDTH-1:0] active configuration word
//   cfg_done   out  last frame loaded, cfg_out valid
//   cfg_err    out  last frame failed its checksum
//   fsm_state  out  [2:0] current FSM state, for debug/observation
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready are
// both 1. in_ready does not depend on in_valid; the sender may hold in_valid
// low for any number of cycles (no timeout) and the FSM simply stalls.
// -----------------------------------------------------------------------------
module config_loader #(
   parameter int          CFG_WIDTH = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic [CFG_WIDTH-1:0] cfg_out,
   output logic                 cfg_done,
   output logic                 cfg_err,
   output logic [2:0]           fsm_state
);

   localparam int NBYTES = CFG_WIDTH / 8;
   localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HUNT  = 3'd1,
      LOAD  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [CFG_WIDTH-1:0]   shadow_q, shadow_d;
   logic [CFG_WIDTH-1:0]   cfg_q, cfg_d;
   logic [7:0]             csum_q, csum_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   accept;

   // Ready is a pure state decode so there is no path from in_valid.
   assign in_ready  = (state_q == HUNT) || (state_q == LOAD) || (state_q == CHECK);
   assign accept    = in_valid && in_ready;

   assign cfg_out   = cfg_q;
   assign cfg_done  = done_q;
   assign cfg_err   = err_q;
   assign fsm_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         cfg_q    <= '0;
         csum_q   <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         cfg_q    <= cfg_d;
         csum_q   <= csum_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cfg_d    = cfg_q;
      csum_d   = csum_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      err_d    = err_q;

      unique case (state_q)
         IDLE, DONE, ERR: begin
            // New frame: flags and frame state are cleared, cfg_out is kept
            // so downstream logic keeps the last good configuration.
            if (start) begin
               state_d  = HUNT;
               shadow_d = '0;
               csum_d   = '0;
               cnt_d    = '0;
               done_d   = 1'b0;
               err_d    = 1'b0;
            end
         end

         HUNT: begin
            // Non-sync bytes are consumed and dropped.
            if (accept && (in_data == SYNC_BYTE)) begin
               state_d = LOAD;
            end
         end

         LOAD: begin
            // SYNC_BYTE here is plain data; no resynchronisation mid-frame.
            if (accept) begin
               shadow_d = (shadow_q << 8) | CFG_WIDTH'(in_data);
               csum_d   = csum_q ^ in_data;
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == CW'(NBYTES - 1)) begin
                  state_d = CHECK;
               end
            end
         end

         CHECK: begin
            if (accept) begin
               if (in_data == csum_q) begin
                  cfg_d   = shadow_q;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//
// Directed bench for config_loader (CFG_WIDTH=16, SYNC_BYTE=A5). Each frame
// pushes its expected {cfg_err, cfg_done, cfg_out} into exp_q; a monitor pops
// and compares whenever cfg_done or cfg_err rises. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_config_loader;

   localparam int W = 18;   // {err, done, cfg_out[15:0]}

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HUNT  = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [15:0] cfg_out;
   logic        cfg_done;
   logic        cfg_err;
   logic [2:0]  fsm_state;

   logic [W-1:0] exp_q[$];
   int           n_vec;
   int           n_bad;
   logic         prev_done;
   logic         prev_err;

   config_loader #(
      .CFG_WIDTH (16),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .cfg_out   (cfg_out),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic err, input logic done, input logic [15:0] cfg);
      exp_q.push_back({err, done, cfg});
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
      forever begin
         @(negedge clk);
         if ((cfg_done && !prev_done) || (cfg_err && !prev_err)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_result: got %0h expected none", {cfg_err, cfg_done, cfg_out});
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               if ({cfg_err, cfg_done, cfg_out} !== e) begin
                  n_bad++;
                  $display("FAIL frame_result: got %0h expected %0h", {cfg_err, cfg_done, cfg_out}, e);
               end
            end
         end
         prev_done = cfg_done;
         prev_err  = cfg_err;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offers one byte; returns at the falling edge after it was accepted.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 (byte %0h)", b);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] bytes[$], input int gap);
      foreach (bytes[i]) begin
         send_byte(bytes[i]);
         if (gap > 0 && i < bytes.size() - 1) repeat (gap) @(negedge clk);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();

      // Reset state
      check("rst_cfg_out",  32'(cfg_out),   32'h0);
      check("rst_done",     32'(cfg_done),  32'h0);
      check("rst_err",      32'(cfg_err),   32'h0);
      check("rst_ready",    32'(in_ready),  32'h0);
      check("rst_state",    32'(fsm_state), 32'(S_IDLE));

      // Byte offered in IDLE is not taken
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (3) @(negedge clk);
      check("idle_ready",   32'(in_ready),  32'h0);
      check("idle_state",   32'(fsm_state), 32'(S_IDLE));
      in_valid = 1'b0;

      // Good frame, back-to-back
      pulse_start();
      check("start_state",  32'(fsm_state), 32'(S_HUNT));
      push_exp(1'b0, 1'b1, 16'h1234);
      send_frame('{8'hA5, 8'h12, 8'h34, 8'h26}, 0);
      check("good_ready",   32'(in_ready),  32'h0);
      check("good_cfg",     32'(cfg_out),   32'h1234);
      check("good_state",   32'(fsm_state), 32'(S_DONE));

      // Bad checksum: AB^CD=66, sent 00
      pulse_start();
      check("restart_done", 32'(cfg_done),  32'h0);
      check("restart_cfg",  32'(cfg_out),   32'h1234);
      push_exp(1'b1, 1'b0, 16'h1234);
      send_frame('{8'hA5, 8'hAB, 8'hCD, 8'h00}, 0);
      check("bad_state",    32'(fsm_state), 32'(S_ERR));

      // Hunt past junk, second A5 is data: A5^01=A4
      pulse_start();
      check("err_cleared",  32'(cfg_err),   32'h0);
      push_exp(1'b0, 1'b1, 16'hA501);
      send_frame('{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h01, 8'hA4}, 0);

      // Same good frame with idle gaps
      pulse_start();
      push_exp(1'b0, 1'b1, 16'h1234);
      send_frame('{8'hA5, 8'h12, 8'h34, 8'h26}, 1);
      check("gap_cfg",      32'(cfg_out),   32'h1234);

      // Reset mid-load
      pulse_start();
      send_frame('{8'hA5, 8'h12}, 0);
      check("midload_state", 32'(fsm_state), 32'(S_LOAD));
      #1 rst_n = 1'b0;
      #1;
      check("arst_cfg",     32'(cfg_out),   32'h0);
      check("arst_done",    32'(cfg_done),  32'h0);
      check("arst_state",   32'(fsm_state), 32'(S_IDLE));
      check("arst_ready",   32'(in_ready),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_state", 32'(fsm_state), 32'(S_IDLE));
      pulse_start();
      push_exp(1'b0, 1'b1, 16'h5678);
      send_frame('{8'hA5, 8'h56, 8'h78, 8'h2E}, 0);

      // Start during LOAD is ignored: 9A^BC=26
      pulse_start();
      push_exp(1'b0, 1'b1, 16'h9ABC);
      send_frame('{8'hA5, 8'h9A}, 0);
      pulse_start();
      check("ign_start_state", 32'(fsm_state), 32'(S_LOAD));
      send_frame('{8'hBC, 8'h26}, 0);
      check("ign_start_cfg", 32'(cfg_out),  32'h9ABC);

      // All expected results consumed
      repeat (3) @(negedge clk);
      check("exp_q_empty",  32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
